screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency.
REQ-002 Parameter FRAME_HZ, default 60, frame tick frequency.
REQ-003 Parameter TIMEOUT_FRAMES, default 40, frames allowed between start release and done.
REQ-004 clk  in  1  system clock.
REQ-005 reset_n  in  1  reset, synchronous, active-low; clock clk.
REQ-006 trigger  in  1  one-cycle request to run the saved-screen sequence.
REQ-007 ax_in / bx_in  in  9  corner X coordinates, sampled on an accepted trigger.
REQ-008 ay_in / by_in  in  8  corner Y coordinates, sampled on an accepted trigger.
REQ-009 done  in  1  completion flag from the screen unit; a register in the sixty_signal domain.
REQ-010 sixty_signal  out  1  50% duty frame square wave that clocks the screen unit's frame counter.
REQ-011 start  out  1  level start/stop to the screen unit.
REQ-012 x_position_a / x_position_b  out  9  held corner X coordinates.
REQ-013 y_position_a / y_position_b  out  8  held corner Y coordinates.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 resume  out  1  one-cycle pulse when the sequence completes normally.
REQ-016 timeout  out  1  sticky error flag.

Function
REQ-017 DIV = CLK_HZ/(2*FRAME_HZ), integer division, and DIV SHALL be at least 2.
REQ-018 The divider counter SHALL count 0..DIV-1 and wrap to 0, toggling sixty_signal on each wrap cycle.
REQ-019 The frame tick SHALL be an internal one-cycle pulse on the clk cycle that toggles sixty_signal from 0 to 1.
REQ-020 done SHALL pass through a 2-flop synchronizer before use, giving done_s (2-cycle latency).
REQ-021 FSM states: IDLE, LOAD, ARM, WAIT_DONE, FINISH.
REQ-022 IDLE: trigger=1 captures ax_in/ay_in/bx_in/by_in into the position outputs and moves to LOAD.
REQ-023 Trigger is ignored in every state except IDLE; there is no queueing.
REQ-024 LOAD lasts exactly 1 cycle with start=0, then moves to ARM; positions are stable before start rises.
REQ-025 ARM: start=1; the state stays in ARM until the first frame tick after entry, then moves to WAIT_DONE on the next cycle.
REQ-026 In ARM, start is high across at least one sixty_signal rising edge, which clears the screen unit's counter.
REQ-027 WAIT_DONE: start=0; a frame-count register clears on entry and increments on each frame tick.
REQ-028 WAIT_DONE with done_s=1 moves to FINISH.
REQ-029 WAIT_DONE with the frame count equal to TIMEOUT_FRAMES and done_s=0 sets timeout and moves to IDLE.
REQ-030 If done_s=1 and the timeout limit occur in the same cycle, done_s SHALL win (FINISH, timeout not set).
REQ-031 FINISH lasts 1 cycle, asserts resume=1, then moves to IDLE.
REQ-032 Position outputs SHALL hold their values from capture until the next accepted trigger, including after FINISH and after timeout.
REQ-033 The frame-count register is 6 bits and saturates rather than wrapping.
REQ-034 start SHALL be registered (no combinational path from trigger).

Reset
REQ-035 When reset_n=0 at a clk edge: state IDLE, start=0, sixty_signal=0, divider=0, frame count=0, positions=0, busy=0, resume=0, timeout=0, synchronizer flops=0.
REQ-036 Reset asserted mid-sequence SHALL abort to IDLE without a resume pulse.
REQ-037 timeout is cleared only by reset.

Structure
REQ-038 The FSM state encoding and the DIV computation function SHALL live in the shared package screen_pkg.
REQ-039 The divider and tick logic SHALL be a sub-module named frame_tick_gen (outputs sixty_signal and tick).
REQ-040 Everything else SHALL be in a single module.

Verification (CLK_HZ=1200, FRAME_HZ=60: DIV=10, frame=20 cycles)
REQ-041 Check the frame clock: after reset release, sixty_signal toggles every 10 cycles, first rise at cycle 10, and tick is 1 cycle wide.
REQ-042 Check the normal flow:
- Drive trigger with ax=100, ay=50, bx=200, by=120.
- Next cycle: positions=100/50/200/120 and busy=1.
- start rises 1 cycle later and stays high through one sixty_signal rise.
- Drive done=1 30 frames later; resume pulses exactly 3-4 cycles after done (2 sync cycles, then FINISH).
REQ-043 Check the timeout: hold done=0 and check timeout=1 at the 40th frame tick in WAIT_DONE, with state IDLE and positions held.
REQ-044 Check trigger rejection: a trigger during WAIT_DONE with ax=5 leaves x_position_a=100 and the sequence unchanged.
REQ-045 Check reset during ARM: start=0 and busy=0 next cycle, no resume pulse, and positions=0.
REQ-046 Check the simultaneous case: done_s rises in the same cycle the count reaches 40, giving resume=1 and timeout=0.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and helpers for the saved-screen sequencer.
// Holds the FSM encoding and the frame divider calculation.
package screen_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_WAIT,
      S_FINISH
   } state_t;

   localparam int FCNT_W = 6;

   function automatic int calc_div(
      input int clk_hz,
      input int frame_hz
   );
      return clk_hz / (2 * frame_hz);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame square wave divider with a one-cycle tick
// on the cycle that drives sixty_signal from 0 to 1.
module frame_tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset_n,
   output logic sixty_signal,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          sixty_q;
   logic          wrap;

   assign wrap = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         sixty_q <= 1'b0;
      end else if (wrap) begin
         cnt_q   <= '0;
         sixty_q <= ~sixty_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign sixty_signal = sixty_q;
   assign tick         = wrap & ~sixty_q;

endmodule

// File: rtl/screen_sequencer.sv
// Saved-screen sequencer: captures corners, pulses start
// across a frame edge, then waits for done or a frame timeout.
module screen_sequencer
   import screen_pkg::*;
#(
   parameter int CLK_HZ         = 50000000,
   parameter int FRAME_HZ       = 60,
   parameter int TIMEOUT_FRAMES = 40
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       trigger,
   input  logic [8:0] ax_in,
   input  logic [8:0] bx_in,
   input  logic [7:0] ay_in,
   input  logic [7:0] by_in,
   input  logic       done,
   output logic       sixty_signal,
   output logic       start,
   output logic [8:0] x_position_a,
   output logic [8:0] x_position_b,
   output logic [7:0] y_position_a,
   output logic [7:0] y_position_b,
   output logic       busy,
   output logic       resume,
   output logic       timeout
);

   localparam int DIV = calc_div(CLK_HZ, FRAME_HZ);
   localparam logic [FCNT_W-1:0] LIMIT =
      FCNT_W'(TIMEOUT_FRAMES);

   logic tick;

   frame_tick_gen #(.DIV(DIV)) u_tick (
      .clk          (clk),
      .reset_n      (reset_n),
      .sixty_signal (sixty_signal),
      .tick         (tick)
   );

   logic sync1_q, sync2_q, done_s;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= done;
         sync2_q <= sync1_q;
      end
   end

   assign done_s = sync2_q;

   state_t            state_q;
   logic [FCNT_W-1:0] fcnt_q;
   logic              armed_q;
   logic              start_q, busy_q;
   logic              resume_q, timeout_q;
   logic [8:0]        xa_q, xb_q;
   logic [7:0]        ya_q, yb_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         fcnt_q    <= '0;
         armed_q   <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         resume_q  <= 1'b0;
         timeout_q <= 1'b0;
         xa_q      <= '0;
         xb_q      <= '0;
         ya_q      <= '0;
         yb_q      <= '0;
      end else begin
         resume_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  xa_q    <= ax_in;
                  ya_q    <= ay_in;
                  xb_q    <= bx_in;
                  yb_q    <= by_in;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               armed_q <= 1'b0;
               start_q <= 1'b1;
               state_q <= S_ARM;
            end
            S_ARM: begin
               // leave one cycle after the tick so start spans the edge
               if (tick) armed_q <= 1'b1;
               if (armed_q) begin
                  start_q <= 1'b0;
                  fcnt_q  <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (tick && (fcnt_q != '1))
                  fcnt_q <= fcnt_q + 1'b1;
               if (done_s) begin
                  resume_q <= 1'b1;
                  state_q  <= S_FINISH;
               end else if (fcnt_q == LIMIT) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            S_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign start        = start_q;
   assign busy         = busy_q;
   assign resume       = resume_q;
   assign timeout      = timeout_q;
   assign x_position_a = xa_q;
   assign x_position_b = xb_q;
   assign y_position_a = ya_q;
   assign y_position_b = yb_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer at DIV=10.
// Completion events are queued by stimulus and checked by a monitor.
module tb_screen_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       trigger = 1'b0;
   logic [8:0] ax_in = '0, bx_in = '0;
   logic [7:0] ay_in = '0, by_in = '0;
   logic       done = 1'b0;
   logic       sixty_signal, start, busy, resume, timeout;
   logic [8:0] x_position_a, x_position_b;
   logic [7:0] y_position_a, y_position_b;

   screen_sequencer #(
      .CLK_HZ(1200), .FRAME_HZ(60), .TIMEOUT_FRAMES(40)
   ) dut (
      .clk(clk), .reset_n(reset_n), .trigger(trigger),
      .ax_in(ax_in), .bx_in(bx_in), .ay_in(ay_in), .by_in(by_in),
      .done(done), .sixty_signal(sixty_signal), .start(start),
      .x_position_a(x_position_a), .x_position_b(x_position_b),
      .y_position_a(y_position_a), .y_position_b(y_position_b),
      .busy(busy), .resume(resume), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_to;
      int         min_c;
      int         max_c;
      logic [8:0] xa, xb;
      logic [7:0] ya, yb;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   prev_sixty = 0;
   bit   rise = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rise = sixty_signal && !prev_sixty;
      prev_sixty = sixty_signal;
   endtask

   task automatic fire(input int xa, input int ya,
                       input int xb, input int yb);
      trigger = 1'b1;
      ax_in = 9'(xa); ay_in = 8'(ya);
      bx_in = 9'(xb); by_in = 8'(yb);
      step();
      trigger = 1'b0;
   endtask

   task automatic push(input bit is_to, input int mn, input int mx,
                       input int xa, input int ya,
                       input int xb, input int yb);
      exp_t e;
      e.is_to = is_to; e.min_c = mn; e.max_c = mx;
      e.xa = 9'(xa); e.ya = 8'(ya); e.xb = 9'(xb); e.yb = 8'(yb);
      q.push_back(e);
   endtask

   task automatic wait_wait_done(input string name);
      int n = 0;
      while (!start && n < 10) begin step(); n++; end
      while (start && n < 60) begin step(); n++; end
      if (n >= 60 || start) chk({name, "_enter_wait"}, 0, 1);
   endtask

   // monitor: one pop per rising resume or timeout
   bit m_res = 0, m_to = 0;
   task automatic mon_event(input bit is_to);
      exp_t e;
      if (q.size() == 0) begin
         chk(is_to ? "unexpected_timeout" : "unexpected_resume", 1, 0);
         return;
      end
      e = q.pop_front();
      chk("event_kind", int'(is_to), int'(e.is_to));
      chk("event_cycle_in_window",
          int'(cyc >= e.min_c && cyc <= e.max_c), 1);
      chk("event_xa", int'(x_position_a), int'(e.xa));
      chk("event_ya", int'(y_position_a), int'(e.ya));
      chk("event_xb", int'(x_position_b), int'(e.xb));
      chk("event_yb", int'(y_position_b), int'(e.yb));
   endtask

   always @(negedge clk) begin
      if (resume && !m_res) mon_event(1'b0);
      if (timeout && !m_to) mon_event(1'b1);
      m_res = resume;
      m_to  = timeout;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got time-out expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int frames, n, t_edge;
      bit seen;

      // frame clock after reset release
      reset_n = 1'b0;
      repeat (3) step();
      chk("reset_start", int'(start), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_sixty", int'(sixty_signal), 0);
      chk("reset_timeout", int'(timeout), 0);
      chk("reset_xa", int'(x_position_a), 0);
      reset_n = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (i == 9) begin
            chk("sixty_c9", int'(sixty_signal), 0);
            chk("tick_c9", int'(dut.tick), 1);
         end
         if (i == 10) begin
            chk("sixty_c10", int'(sixty_signal), 1);
            chk("tick_c10", int'(dut.tick), 0);
         end
         if (i == 19) chk("tick_c19", int'(dut.tick), 0);
         if (i == 20) chk("sixty_c20", int'(sixty_signal), 0);
         if (i == 30) chk("sixty_c30", int'(sixty_signal), 1);
      end

      // normal flow with a rejected trigger in WAIT_DONE
      fire(100, 50, 200, 120);
      chk("cap_xa", int'(x_position_a), 100);
      chk("cap_ya", int'(y_position_a), 50);
      chk("cap_xb", int'(x_position_b), 200);
      chk("cap_yb", int'(y_position_b), 120);
      chk("cap_busy", int'(busy), 1);
      chk("load_start", int'(start), 0);
      step();
      chk("arm_start", int'(start), 1);
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         step(); n++;
         if (rise) begin
            seen = 1;
            chk("start_at_rise", int'(start), 1);
         end
      end
      chk("arm_rise_seen", int'(seen), 1);
      step();
      chk("wait_start_low", int'(start), 0);
      frames = 0; n = 0; seen = 0;
      while (frames < 30 && n < 700) begin
         step(); n++;
         if (trigger) begin
            trigger = 1'b0;
            chk("reject_xa", int'(x_position_a), 100);
            chk("reject_busy", int'(busy), 1);
            chk("reject_start", int'(start), 0);
         end
         if (rise) frames++;
         if (frames == 5 && !seen) begin
            seen = 1;
            trigger = 1'b1;
            ax_in = 9'd5; ay_in = 8'd6; bx_in = 9'd7; by_in = 8'd8;
         end
      end
      chk("normal_30_frames", frames, 30);
      done = 1'b1;
      push(0, cyc + 3, cyc + 4, 100, 50, 200, 120);
      n = 0;
      while (!resume && n < 10) begin step(); n++; end
      chk("resume_seen", int'(resume), 1);
      step();
      chk("resume_one_cycle", int'(resume), 0);
      chk("finish_idle_busy", int'(busy), 0);
      chk("hold_after_finish_xa", int'(x_position_a), 100);
      chk("no_timeout_normal", int'(timeout), 0);
      done = 1'b0;
      repeat (4) step();

      // timeout: done stays low
      fire(10, 20, 30, 40);
      wait_wait_done("to");
      frames = 0; n = 0;
      while (frames < 40 && n < 900) begin
         step(); n++;
         if (rise) frames++;
      end
      chk("to_40_frames", frames, 40);
      chk("to_not_yet", int'(timeout), 0);
      push(1, cyc + 1, cyc + 2, 10, 20, 30, 40);
      n = 0;
      while (!timeout && n < 5) begin step(); n++; end
      chk("timeout_set", int'(timeout), 1);
      chk("timeout_idle", int'(busy), 0);
      chk("timeout_start", int'(start), 0);
      chk("timeout_hold_xb", int'(x_position_b), 30);
      repeat (25) step();
      chk("timeout_sticky", int'(timeout), 1);
      chk("timeout_no_restart", int'(busy), 0);

      // reset during ARM
      fire(1, 2, 3, 4);
      step();
      chk("rarm_start", int'(start), 1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("rarm_start_low", int'(start), 0);
      chk("rarm_busy", int'(busy), 0);
      chk("rarm_xa", int'(x_position_a), 0);
      chk("rarm_yb", int'(y_position_b), 0);
      chk("rarm_timeout", int'(timeout), 0);
      seen = 0;
      prev_sixty = sixty_signal;
      repeat (40) begin
         step();
         if (resume || busy || start) seen = 1;
      end
      chk("rarm_quiet", int'(seen), 0);

      // done_s and the limit coincide
      fire(300, 200, 400, 250);
      wait_wait_done("sim");
      frames = 0; n = 0;
      while (frames < 39 && n < 900) begin
         step(); n++;
         if (rise) frames++;
      end
      chk("sim_39_frames", frames, 39);
      t_edge = cyc + 20;
      n = 0;
      while (cyc < t_edge - 2 && n < 30) begin step(); n++; end
      done = 1'b1;
      push(0, t_edge + 1, t_edge + 1, 300, 200, 400, 250);
      n = 0;
      while (!resume && n < 10) begin
         step(); n++;
         if (rise) chk("sim_40th_edge", cyc, t_edge);
      end
      chk("sim_resume", int'(resume), 1);
      chk("sim_no_timeout", int'(timeout), 0);
      done = 1'b0;
      repeat (5) step();
      chk("sim_timeout_after", int'(timeout), 0);
      chk("sim_idle", int'(busy), 0);
      chk("sim_hold_xa", int'(x_position_a), 300);

      repeat (3) step();
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
